// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding, transaction owner encoding, bus widths and timeout counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  // Wide enough for any practical TIMEOUT value
  localparam int CNT_W = 16;

  // Round-robin pointer: which requester wins a simultaneous request
  localparam logic PTR_D_FIRST  = 1'b0;
  localparam logic PTR_IF_FIRST = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the hart fetch port, hart data port and memory port signals.
// The slave modport is the arbiter's view; master is the hart+memory view.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_ready;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;
  logic              o_if_err;

  logic              i_d_req;
  logic [ADDR_W-1:0] i_d_addr;
  logic              i_d_ren;
  logic              i_d_wen;
  logic [DATA_W-1:0] i_d_wdata;
  logic [MASK_W-1:0] i_d_mask;
  logic              o_d_ready;
  logic              o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;
  logic              o_d_err;

  logic              o_mem_valid;
  logic              i_mem_ready;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_wen;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [MASK_W-1:0] o_mem_mask;
  logic              i_mem_rvalid;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_ready, o_if_rvalid, o_if_rdata, o_if_err,
    input  i_d_req, i_d_addr, i_d_ren, i_d_wen, i_d_wdata, i_d_mask,
    output o_d_ready, o_d_rvalid, o_d_rdata, o_d_err,
    output o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_ready, o_if_rvalid, o_if_rdata, o_if_err,
    output i_d_req, i_d_addr, i_d_ren, i_d_wen, i_d_wdata, i_d_mask,
    input  o_d_ready, o_d_rvalid, o_d_rdata, o_d_err,
    input  o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests. Data wins a tie unless the
// pointer says fetch goes first; a lone requester always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic rr_ptr_i,
  output logic grant_if_o,
  output logic grant_d_o
);

  // Resolve a tie with the pointer, otherwise grant whoever is asking
  always_comb begin
    grant_d_o  = d_req_i & (~if_req_i | (rr_ptr_i == PTR_D_FIRST));
    grant_if_o = if_req_i & ~grant_d_o;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the hart's fetch and data ports.
// One transaction in flight at a time: accept (IDLE), issue (ISSUE), wait for
// the response (WAIT), which is routed back to the owner of the transaction.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise
// data has fixed priority over fetch.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input logic          i_clk,
  input logic          i_rst,
  mem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rrPtr_q, rrPtr_d;
  logic              errPend_q, errPend_d;

  logic              grantIf, grantD;
  logic              ifReady, dReady, memValid;
  logic              rspValid, rspErr, dErrRsp;
  logic [DATA_W-1:0] rspData;

  mem_arb_pick uPick (
    .if_req_i   (bus.i_if_req),
    .d_req_i    (bus.i_d_req),
    .rr_ptr_i   (rrPtr_q),
    .grant_if_o (grantIf),
    .grant_d_o  (grantD)
  );

  // Next-state logic: accept and latch in IDLE, hold the request in ISSUE,
  // and finish on a memory response or timeout in WAIT. Nothing is granted or
  // returned while reset is asserted.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    rrPtr_d   = rrPtr_q;
    errPend_d = 1'b0;
    ifReady   = 1'b0;
    dReady    = 1'b0;
    memValid  = 1'b0;
    rspValid  = 1'b0;
    rspErr    = 1'b0;
    rspData   = '0;
    dErrRsp   = 1'b0;
    if (!i_rst) begin
      unique case (state_q)
        S_IDLE: begin
          dErrRsp = errPend_q;
          if (grantD) begin
            dReady = 1'b1;
            if (bus.i_d_ren && bus.i_d_wen) begin
              errPend_d = 1'b1;
            end else begin
              owner_d = OWN_D;
              addr_d  = bus.i_d_addr;
              wen_d   = bus.i_d_wen;
              wdata_d = bus.i_d_wdata;
              mask_d  = bus.i_d_mask;
              state_d = S_ISSUE;
            end
          end else if (grantIf) begin
            ifReady = 1'b1;
            owner_d = OWN_IF;
            addr_d  = bus.i_if_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            mask_d  = '1;
            state_d = S_ISSUE;
          end
`ifdef MEM_ARB_RR_EN
          if (grantD) begin
            rrPtr_d = PTR_IF_FIRST;
          end else if (grantIf) begin
            rrPtr_d = PTR_D_FIRST;
          end
`endif
        end
        S_ISSUE: begin
          memValid = 1'b1;
          if (bus.i_mem_ready) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
        S_WAIT: begin
          if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT))) begin
            rspValid = 1'b1;
            rspErr   = 1'b1;
            state_d  = S_IDLE;
          end else if (bus.i_mem_rvalid) begin
            rspValid = 1'b1;
            rspData  = bus.i_mem_rdata;
            state_d  = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Route the response to its owner and present the latched request only
  // while it is being issued, so the memory bus reads zero otherwise
  always_comb begin
    bus.o_if_ready  = ifReady;
    bus.o_d_ready   = dReady;
    bus.o_if_rvalid = rspValid && (owner_q == OWN_IF);
    bus.o_if_err    = rspErr && (owner_q == OWN_IF);
    bus.o_if_rdata  = (owner_q == OWN_IF) ? rspData : '0;
    bus.o_d_rvalid  = (rspValid && (owner_q == OWN_D)) || dErrRsp;
    bus.o_d_err     = (rspErr && (owner_q == OWN_D)) || dErrRsp;
    bus.o_d_rdata   = (owner_q == OWN_D) ? rspData : '0;
    bus.o_mem_valid = memValid;
    bus.o_mem_addr  = memValid ? addr_q : '0;
    bus.o_mem_wen   = memValid && wen_q;
    bus.o_mem_wdata = memValid ? wdata_q : '0;
    bus.o_mem_mask  = memValid ? mask_q : '0;
  end

  // State and latched-request registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_IF;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      rrPtr_q   <= PTR_D_FIRST;
      errPend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      rrPtr_q   <= rrPtr_d;
      errPend_q <= errPend_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// transactions checked against a transaction-level timing model.
// Honours MEM_ARB_RR_EN in its arbitration model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;
  logic dFirst;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Flags: if_ready, d_ready, if_rvalid, d_rvalid, if_err, d_err, mem_valid
  logic [6:0]   obsFlags;
  logic [68:0]  obsFields;
  logic [139:0] obsAll;
  assign obsFlags  = {bus.o_if_ready, bus.o_d_ready, bus.o_if_rvalid, bus.o_d_rvalid,
                      bus.o_if_err, bus.o_d_err, bus.o_mem_valid};
  assign obsFields = {bus.o_mem_addr, bus.o_mem_wen, bus.o_mem_wdata, bus.o_mem_mask};
  assign obsAll    = {obsFlags, bus.o_if_rdata, bus.o_d_rdata, obsFields};

  task automatic idleInputs();
    bus.i_if_req     = 1'b0;
    bus.i_if_addr    = '0;
    bus.i_d_req      = 1'b0;
    bus.i_d_addr     = '0;
    bus.i_d_ren      = 1'b0;
    bus.i_d_wen      = 1'b0;
    bus.i_d_wdata    = '0;
    bus.i_d_mask     = '0;
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleInputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dFirst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idleInputs();
    bus.i_if_req = 1'b1;
    bus.i_d_req  = 1'b1;
    bus.i_d_ren  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    vecs++;
    if (obsAll !== '0) begin
      errs++;
      $display("[TB] FAIL reset_held got %h want 0", obsAll);
    end
    rst = 1'b0;
    idleInputs();
    dFirst = 1'b1;
    nextCycle();
    vecs++;
    if (obsAll !== '0) begin
      errs++;
      $display("[TB] FAIL reset_idle got %h want 0", obsAll);
    end
  endtask

  task automatic test_fetch_only();
    doReset();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h100;
    #1;
    vecs++;
    if (obsFlags !== 7'b1000000) begin
      errs++;
      $display("[TB] FAIL fetch_accept flags got %b want %b", obsFlags, 7'b1000000);
    end
    nextCycle();
    bus.i_if_req    = 1'b0;
    bus.i_mem_ready = 1'b1;
    #1;
    vecs++;
    if ({obsFlags, obsFields} !== {7'b0000001, 32'h100, 1'b0, 32'h0, 4'hF}) begin
      errs++;
      $display("[TB] FAIL fetch_issue got %b/%h want 0000001/%h", obsFlags, obsFields,
               {32'h100, 1'b0, 32'h0, 4'hF});
    end
    nextCycle();
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h00500093;
    #1;
    vecs++;
    if ({obsFlags, bus.o_if_rdata} !== {7'b0010000, 32'h00500093}) begin
      errs++;
      $display("[TB] FAIL fetch_resp got %b/%h want 0010000/00500093", obsFlags, bus.o_if_rdata);
    end
    nextCycle();
    idleInputs();
    #1;
    vecs++;
    if (obsFlags !== 7'b0) begin
      errs++;
      $display("[TB] FAIL fetch_done flags got %b want 0", obsFlags);
    end
  endtask

  task automatic test_simultaneous();
    doReset();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h104;
    bus.i_d_req   = 1'b1;
    bus.i_d_addr  = 32'h200;
    bus.i_d_wen   = 1'b1;
    bus.i_d_wdata = 32'hDEADBEEF;
    bus.i_d_mask  = 4'hF;
    #1;
    vecs++;
    if (obsFlags !== 7'b0100000) begin
      errs++;
      $display("[TB] FAIL simul_accept flags got %b want 0100000", obsFlags);
    end
    nextCycle();
    bus.i_d_req     = 1'b0;
    bus.i_mem_ready = 1'b1;
    #1;
    vecs++;
    if ({obsFlags, obsFields} !== {7'b0000001, 32'h200, 1'b1, 32'hDEADBEEF, 4'hF}) begin
      errs++;
      $display("[TB] FAIL simul_issue got %b/%h want 0000001/%h", obsFlags, obsFields,
               {32'h200, 1'b1, 32'hDEADBEEF, 4'hF});
    end
    nextCycle();
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    #1;
    vecs++;
    if (obsFlags !== 7'b0001000) begin
      errs++;
      $display("[TB] FAIL simul_ack flags got %b want 0001000", obsFlags);
    end
    nextCycle();
    bus.i_mem_rvalid = 1'b0;
    #1;
    vecs++;
    if (obsFlags !== 7'b1000000) begin
      errs++;
      $display("[TB] FAIL simul_fetch_ready flags got %b want 1000000", obsFlags);
    end
    nextCycle();
    bus.i_if_req    = 1'b0;
    bus.i_mem_ready = 1'b1;
    #1;
    vecs++;
    if ({obsFlags, obsFields} !== {7'b0000001, 32'h104, 1'b0, 32'h0, 4'hF}) begin
      errs++;
      $display("[TB] FAIL simul_fetch_issue got %b/%h", obsFlags, obsFields);
    end
    nextCycle();
    idleInputs();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h13;
    #1;
    vecs++;
    if ({obsFlags, bus.o_if_rdata} !== {7'b0010000, 32'h13}) begin
      errs++;
      $display("[TB] FAIL simul_fetch_resp got %b/%h want 0010000/13", obsFlags, bus.o_if_rdata);
    end
    nextCycle();
    idleInputs();
  endtask

  task automatic test_illegal();
    doReset();
    bus.i_d_req  = 1'b1;
    bus.i_d_ren  = 1'b1;
    bus.i_d_wen  = 1'b1;
    bus.i_d_addr = 32'h40;
    #1;
    vecs++;
    if (obsFlags !== 7'b0100000) begin
      errs++;
      $display("[TB] FAIL illegal_accept flags got %b want 0100000", obsFlags);
    end
    nextCycle();
    idleInputs();
    #1;
    vecs++;
    if (obsFlags !== 7'b0001010) begin
      errs++;
      $display("[TB] FAIL illegal_err flags got %b want 0001010", obsFlags);
    end
    nextCycle();
    vecs++;
    if (obsFlags !== 7'b0) begin
      errs++;
      $display("[TB] FAIL illegal_after flags got %b want 0", obsFlags);
    end
  endtask

  task automatic test_timeout();
    doReset();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h300;
    nextCycle();
    bus.i_if_req    = 1'b0;
    bus.i_mem_ready = 1'b1;
    nextCycle();
    bus.i_mem_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #1;
      vecs++;
      if (obsFlags !== 7'b0) begin
        errs++;
        $display("[TB] FAIL timeout_wait%0d flags got %b want 0", i, obsFlags);
      end
      nextCycle();
    end
    #1;
    vecs++;
    if ({obsFlags, bus.o_if_rdata} !== {7'b0010100, 32'h0}) begin
      errs++;
      $display("[TB] FAIL timeout_err got %b/%h want 0010100/0", obsFlags, bus.o_if_rdata);
    end
    nextCycle();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'h55AA55AA;
    #1;
    vecs++;
    if (obsFlags !== 7'b0) begin
      errs++;
      $display("[TB] FAIL timeout_stray flags got %b want 0", obsFlags);
    end
    nextCycle();
    idleInputs();
  endtask

  task automatic test_stall();
    doReset();
    bus.i_d_req   = 1'b1;
    bus.i_d_ren   = 1'b1;
    bus.i_d_addr  = 32'h44;
    bus.i_d_mask  = 4'h3;
    bus.i_d_wdata = 32'h12345678;
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h80;
    #1;
    vecs++;
    if (obsFlags !== 7'b0100000) begin
      errs++;
      $display("[TB] FAIL stall_accept flags got %b want 0100000", obsFlags);
    end
    for (int k = 0; k < 6; k++) begin
      nextCycle();
      bus.i_d_req     = 1'b0;
      bus.i_mem_ready = (k == 5);
      #1;
      vecs++;
      if ({obsFlags, obsFields} !== {7'b0000001, 32'h44, 1'b0, 32'h12345678, 4'h3}) begin
        errs++;
        $display("[TB] FAIL stall_hold%0d got %b/%h", k, obsFlags, obsFields);
      end
    end
    nextCycle();
    bus.i_mem_ready  = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'hCAFEF00D;
    #1;
    vecs++;
    if ({obsFlags, bus.o_d_rdata} !== {7'b0001000, 32'hCAFEF00D}) begin
      errs++;
      $display("[TB] FAIL stall_resp got %b/%h want 0001000/cafef00d", obsFlags, bus.o_d_rdata);
    end
    nextCycle();
    idleInputs();
  endtask

  task automatic test_reset_mid();
    doReset();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 32'h10;
    nextCycle();
    bus.i_if_req    = 1'b0;
    bus.i_mem_ready = 1'b1;
    nextCycle();
    bus.i_mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    vecs++;
    if (obsAll !== '0) begin
      errs++;
      $display("[TB] FAIL rstmid_during got %h want 0", obsAll);
    end
    nextCycle();
    rst = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 32'hFFFF;
    #1;
    vecs++;
    if (obsAll !== '0) begin
      errs++;
      $display("[TB] FAIL rstmid_stray got %h want 0", obsAll);
    end
    nextCycle();
    idleInputs();
  endtask

  task automatic test_random();
    logic        ifPend, dPend, errNow, wonD, illegal, expErr;
    logic [31:0] ifAddr, dAddr, dWdata, memRdata, expData, gotData;
    logic        dRen, dWen;
    logic [3:0]  dMask;
    logic [68:0] expFields;
    logic [6:0]  expFlags;
    int          rd, rl, sel;
    doReset();
    ifPend = 1'b0; dPend = 1'b0; errNow = 1'b0;
    ifAddr = '0; dAddr = '0; dWdata = '0; dRen = 1'b0; dWen = 1'b0; dMask = '0;
    for (int t = 0; t < 300; t++) begin
      nextCycle();
      if (!ifPend && $urandom_range(0, 2) != 0) begin
        ifPend = 1'b1;
        ifAddr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!dPend && $urandom_range(0, 2) != 0) begin
        dPend  = 1'b1;
        dAddr  = $urandom() & 32'hFFFF_FFFC;
        dWdata = $urandom();
        dMask  = 4'($urandom_range(0, 15));
        sel    = int'($urandom_range(0, 9));
        dRen   = (sel == 0) || (sel >= 2 && sel <= 5);
        dWen   = (sel == 0) || (sel >= 6);
      end
      bus.i_if_req     = ifPend;
      bus.i_if_addr    = ifAddr;
      bus.i_d_req      = dPend;
      bus.i_d_addr     = dAddr;
      bus.i_d_ren      = dRen;
      bus.i_d_wen      = dWen;
      bus.i_d_wdata    = dWdata;
      bus.i_d_mask     = dMask;
      bus.i_mem_ready  = 1'($urandom_range(0, 1));
      bus.i_mem_rvalid = 1'($urandom_range(0, 1));
      bus.i_mem_rdata  = $urandom();
      #1;
      wonD = dPend && (!ifPend || dFirst);
      expFlags = {ifPend && !wonD, wonD, 1'b0, errNow, 1'b0, errNow, 1'b0};
      vecs++;
      if (obsFlags !== expFlags) begin
        errs++;
        $display("[TB] FAIL rand_accept t=%0d flags got %b want %b", t, obsFlags, expFlags);
      end
      errNow = 1'b0;
      if (!ifPend && !dPend) continue;
`ifdef MEM_ARB_RR_EN
      dFirst = !wonD;
`endif
      if (wonD) begin
        dPend     = 1'b0;
        illegal   = dRen && dWen;
        expFields = {dAddr, dWen, dWdata, dMask};
      end else begin
        ifPend    = 1'b0;
        illegal   = 1'b0;
        expFields = {ifAddr, 1'b0, 32'h0, 4'hF};
      end
      if (illegal) begin
        errNow = 1'b1;
        continue;
      end
      rd = int'($urandom_range(0, 3));
      rl = int'($urandom_range(0, 6));
      for (int k = 0; k <= rd; k++) begin
        nextCycle();
        bus.i_if_req     = ifPend;
        bus.i_d_req      = dPend;
        bus.i_mem_ready  = (k == rd);
        bus.i_mem_rvalid = 1'($urandom_range(0, 1));
        #1;
        vecs++;
        if ({obsFlags, obsFields} !== {7'b0000001, expFields}) begin
          errs++;
          $display("[TB] FAIL rand_issue t=%0d got %b/%h want 0000001/%h", t, obsFlags,
                   obsFields, expFields);
        end
      end
      for (int idx = 0; idx <= TO; idx++) begin
        nextCycle();
        memRdata         = $urandom();
        bus.i_mem_ready  = 1'b0;
        bus.i_mem_rvalid = (idx == rl);
        bus.i_mem_rdata  = memRdata;
        #1;
        if (idx == TO || idx == rl) begin
          expErr   = (idx == TO);
          expData  = expErr ? 32'h0 : memRdata;
          expFlags = {2'b00, !wonD, wonD, !wonD && expErr, wonD && expErr, 1'b0};
          gotData  = wonD ? bus.o_d_rdata : bus.o_if_rdata;
          vecs++;
          if ({obsFlags, gotData} !== {expFlags, expData}) begin
            errs++;
            $display("[TB] FAIL rand_resp t=%0d got %b/%h want %b/%h", t, obsFlags, gotData,
                     expFlags, expData);
          end
          break;
        end else begin
          vecs++;
          if (obsFlags !== 7'b0) begin
            errs++;
            $display("[TB] FAIL rand_wait t=%0d flags got %b want 0", t, obsFlags);
          end
        end
      end
    end
    nextCycle();
    idleInputs();
    #1;
    expFlags = {3'b000, errNow, 1'b0, errNow, 1'b0};
    vecs++;
    if (obsFlags !== expFlags) begin
      errs++;
      $display("[TB] FAIL rand_final flags got %b want %b", obsFlags, expFlags);
    end
  endtask

  initial begin
    rst = 1'b1;
    dFirst = 1'b1;
    idleInputs();
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_illegal();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
